// File: rtl/serdes_scramble_pkg.sv
// Shared definitions for the LVDS lane interleaver and its receive-side descramble:
// lane geometry, FSM states, PRBS-7 constants and the interleave index mapping.
package serdes_scramble_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned LANE_BITS  = 8;
  localparam int unsigned WORD_W     = LANES * LANE_BITS;
  localparam int unsigned IDX_W      = $clog2(WORD_W);
  localparam int unsigned LANE_IDX_W = $clog2(LANES);
  localparam int unsigned BIT_IDX_W  = $clog2(LANE_BITS);
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned UF_W       = 16;
  localparam int unsigned PRBS_W     = 7;

  // x^7 + x^6 + 1: feedback from state bits 6 and 5
  localparam logic [PRBS_W-1:0] PRBS7_SEED = 7'h7F;
  localparam logic [PRBS_W-1:0] PRBS7_TAPS = 7'h60;

  typedef enum logic [1:0] {IDLE, TRAIN, RUN} state_t;

  typedef logic [LANE_BITS-1:0] lane_t;
  typedef lane_t [LANES-1:0]    lanes_t;

  // Word bit carrying lane `lane`, bit `bit_pos`; bit 7 of every lane lands in the first byte.
  function automatic logic [IDX_W-1:0] lvds_index(input int unsigned lane, input int unsigned bit_pos);
    return IDX_W'((LANE_BITS - 1 - bit_pos) * LANES + (LANES - 1 - lane));
  endfunction

  function automatic logic [WORD_W-1:0] interleave(input lanes_t lanes);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned b = 0; b < LANE_BITS; b++) begin
        w[lvds_index(l, b)] = lanes[LANE_IDX_W'(l)][BIT_IDX_W'(b)];
      end
    end
    return w;
  endfunction

  function automatic lanes_t broadcast(input lane_t value);
    lanes_t r;
    for (int unsigned l = 0; l < LANES; l++) begin
      r[LANE_IDX_W'(l)] = value;
    end
    return r;
  endfunction

  // One LFSR shift; the newly produced bit enters at bit 0 and is the serial output.
  function automatic logic [PRBS_W-1:0] prbs7_step(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/serdes_scramble_if.sv
// Lane-byte handshake and OSERDES word bus of the transmit interleaver.
interface serdes_scramble_if;
  import serdes_scramble_pkg::*;

  logic              i_enable;
  logic              i_train_req;
  logic              i_valid;
  lane_t             i_lvds0;
  lane_t             i_lvds1;
  lane_t             i_lvds2;
  lane_t             i_lvds3;
  lane_t             i_lvds4;
  lane_t             i_lvds5;
  lane_t             i_lvds6;
  lane_t             i_lvds7;
  logic              o_ready;
  logic [WORD_W-1:0] o_lvds;
  logic              o_train_active;
  logic [UF_W-1:0]   o_underflow_count;

  modport master (
    output i_enable, i_train_req, i_valid,
    output i_lvds0, i_lvds1, i_lvds2, i_lvds3, i_lvds4, i_lvds5, i_lvds6, i_lvds7,
    input  o_ready, o_lvds, o_train_active, o_underflow_count
  );

  modport slave (
    input  i_enable, i_train_req, i_valid,
    input  i_lvds0, i_lvds1, i_lvds2, i_lvds3, i_lvds4, i_lvds5, i_lvds6, i_lvds7,
    output o_ready, o_lvds, o_train_active, o_underflow_count
  );
endinterface

// File: rtl/serdes_scramble_prbs.sv
// PRBS-7 byte source for training words: o_byte holds the next 8 LFSR output bits,
// first bit in the MSB; i_advance consumes them, i_load reseeds.
module serdes_prbs7_byte
  import serdes_scramble_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  logic  i_advance,
  output lane_t o_byte
);

  logic [PRBS_W-1:0] lfsr_q;
  logic [PRBS_W-1:0] lfsr_adv;

  always_comb begin
    lfsr_adv = lfsr_q;
    o_byte   = '0;
    for (int unsigned i = 0; i < LANE_BITS; i++) begin
      lfsr_adv = prbs7_step(lfsr_adv);
      o_byte[BIT_IDX_W'(LANE_BITS - 1 - i)] = lfsr_adv[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            lfsr_q <= PRBS7_SEED;
    else if (i_load)    lfsr_q <= PRBS7_SEED;
    else if (i_advance) lfsr_q <= lfsr_adv;
  end

endmodule

// File: rtl/serdes_scramble.sv
// Transmit lane interleaver with IDLE/TRAIN/RUN sequencing for the OSERDES bank.
// Define SERDES_SCRAMBLE_PRBS_EN for PRBS-7 training bytes instead of TRAIN_BYTE.
module serdes_scramble
  import serdes_scramble_pkg::*;
#(
  parameter int unsigned TRAIN_WORDS = 64,
  parameter lane_t       TRAIN_BYTE  = 8'hA5,
  parameter lane_t       IDLE_BYTE   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  serdes_scramble_if.slave  bus
);

  localparam logic [WORD_W-1:0] IDLE_WORD = interleave(broadcast(IDLE_BYTE));
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(TRAIN_WORDS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] lvds_d;
  logic              train_d;
  logic [UF_W-1:0]   uf_d;
  logic              train_start_c;
  lane_t             train_byte_c;
  lanes_t            lanes_c;

  assign lanes_c = {bus.i_lvds7, bus.i_lvds6, bus.i_lvds5, bus.i_lvds4,
                    bus.i_lvds3, bus.i_lvds2, bus.i_lvds1, bus.i_lvds0};

  // A training request wins over an accept so the pending word stays with the source.
  assign bus.o_ready = (state_q == RUN) && bus.i_enable && !bus.i_train_req;

`ifdef SERDES_SCRAMBLE_PRBS_EN
  serdes_prbs7_byte u_prbs (
    .clk       (clk),
    .rst       (rst),
    .i_load    (train_start_c),
    .i_advance ((state_q == TRAIN) && !train_start_c),
    .o_byte    (train_byte_c)
  );
`else
  assign train_byte_c = TRAIN_BYTE;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lvds_d        = IDLE_WORD;
    train_d       = 1'b0;
    uf_d          = bus.o_underflow_count;
    train_start_c = 1'b0;
    if (!bus.i_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d       = TRAIN;
          cnt_d         = '0;
          train_start_c = 1'b1;
        end
        TRAIN: begin
          lvds_d  = interleave(broadcast(train_byte_c));
          train_d = 1'b1;
          if (bus.i_train_req) begin
            cnt_d         = '0;
            train_start_c = 1'b1;
          end else if (cnt_q == LAST_WORD) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (bus.i_train_req) begin
            state_d       = TRAIN;
            cnt_d         = '0;
            train_start_c = 1'b1;
          end else if (bus.i_valid) begin
            lvds_d = interleave(lanes_c);
          end else if (bus.o_underflow_count != '1) begin
            uf_d = bus.o_underflow_count + UF_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q               <= IDLE;
      cnt_q                 <= '0;
      bus.o_lvds            <= IDLE_WORD;
      bus.o_train_active    <= 1'b0;
      bus.o_underflow_count <= '0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      bus.o_lvds            <= lvds_d;
      bus.o_train_active    <= train_d;
      bus.o_underflow_count <= uf_d;
    end
  end

endmodule

// File: tb/tb_serdes_scramble.sv
// Scoreboard bench for serdes_scramble with TRAIN_WORDS=4: stimulus queues the expected
// word per cycle, a negedge monitor pops and compares (plus a descramble loopback).
module tb_serdes_scramble;

  localparam int unsigned TW = 4;
  localparam logic [63:0] IDLE_W = 64'h0;
  localparam logic [63:0] A5_W   = 64'hFF00_FF00_00FF_00FF;
  // lane flat vectors: lane L at [L*8 +: 8]
  localparam logic [63:0] P1 = 64'h8040_2010_0804_0201;  // lane L = 8'h01 << L
  localparam logic [63:0] D1 = 64'h8040_2010_0804_0201;
  localparam logic [63:0] P2 = 64'h0102_0408_1020_4080;  // lane L = 8'h80 >> L
  localparam logic [63:0] D2 = 64'h0102_0408_1020_4080;
  localparam logic [63:0] P3 = 64'h0000_0000_0000_00FF;  // lane0 = 8'hFF only
  localparam logic [63:0] D3 = 64'h8080_8080_8080_8080;
  localparam logic [63:0] P4 = 64'hA5A5_A5A5_A5A5_A5A5;

  typedef struct packed {
    logic [63:0] lvds;
    logic        tr;
    logic        chk;
    logic [63:0] lanes;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] uf_exp;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  serdes_scramble_if bus();

  serdes_scramble #(.TRAIN_WORDS(TW), .TRAIN_BYTE(8'hA5), .IDLE_BYTE(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] descramble(input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 8; l++)
      for (int b = 0; b < 8; b++)
        r[6'(l * 8 + b)] = w[6'((7 - b) * 8 + (7 - l))];
    return r;
  endfunction

  function automatic logic [63:0] bcast(input logic [7:0] x);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 8; b++) w[6'((7 - b) * 8) +: 8] = {8{x[3'(b)]}};
    return w;
  endfunction

  // Bit-serial PRBS-7 reference (x^7+x^6+1, seed 7F); byte k of a burst, first bit in MSB.
  function automatic logic [7:0] prbs_ref(input int k);
    logic [6:0] s;
    logic [7:0] b;
    logic       fb;
    s = 7'h7F;
    b = '0;
    for (int i = 0; i <= k; i++)
      for (int j = 0; j < 8; j++) begin
        fb = s[6] ^ s[5];
        s  = {s[5:0], fb};
        b  = {b[6:0], fb};
      end
    return b;
  endfunction

  function automatic logic [63:0] tw(input int k);
`ifdef SERDES_SCRAMBLE_PRBS_EN
    return bcast(prbs_ref(k));
`else
    return (k >= 0) ? A5_W : IDLE_W;
`endif
  endfunction

  task automatic step(input logic en, input logic req, input logic valid, input logic [63:0] lanes,
                      input logic rdy, input logic [63:0] lv, input logic tr, input logic chk);
    bus.i_enable = en; bus.i_train_req = req; bus.i_valid = valid;
    bus.i_lvds0 = lanes[7:0];   bus.i_lvds1 = lanes[15:8];
    bus.i_lvds2 = lanes[23:16]; bus.i_lvds3 = lanes[31:24];
    bus.i_lvds4 = lanes[39:32]; bus.i_lvds5 = lanes[47:40];
    bus.i_lvds6 = lanes[55:48]; bus.i_lvds7 = lanes[63:56];
    #2;
    check("o_ready", 64'(bus.o_ready), 64'(rdy));
    @(posedge clk);
    exp_q.push_back('{lvds: lv, tr: tr, chk: chk, lanes: lanes});
    if (rdy && valid == 1'b0 && uf_exp != 16'hFFFF) uf_exp++;
    #1;
    check("underflow_count", 64'(bus.o_underflow_count), 64'(uf_exp));
  endtask

  task automatic train_burst(input logic valid, input logic [63:0] lanes);
    for (int k = 0; k < int'(TW); k++) step(1'b1, 1'b0, valid, lanes, 1'b0, tw(k), 1'b1, 1'b0);
  endtask

  task automatic data(input logic [63:0] lanes, input logic [63:0] lv);
    step(1'b1, 1'b0, 1'b1, lanes, 1'b1, lv, 1'b0, 1'b1);
  endtask

  task automatic under();
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, IDLE_W, 1'b0, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_lvds"},  bus.o_lvds, IDLE_W);
    check({tag, "_train"}, 64'(bus.o_train_active), 64'h0);
    check({tag, "_ready"}, 64'(bus.o_ready), 64'h0);
    check({tag, "_uf"},    64'(bus.o_underflow_count), 64'h0);
  endtask

  // Monitor: one output word per clock, compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("o_lvds", bus.o_lvds, e.lvds);
        check("o_train_active", 64'(bus.o_train_active), 64'(e.tr));
        if (e.chk) check("loopback", descramble(bus.o_lvds), e.lanes);
      end
    end
  end

  initial begin
    rst = 1'b1; uf_exp = '0;
    bus.i_enable = 1'b0; bus.i_train_req = 1'b0; bus.i_valid = 1'b0;
    bus.i_lvds0 = '0; bus.i_lvds1 = '0; bus.i_lvds2 = '0; bus.i_lvds3 = '0;
    bus.i_lvds4 = '0; bus.i_lvds5 = '0; bus.i_lvds6 = '0; bus.i_lvds7 = '0;
    #13;
    check_reset("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // bring-up: one idle word, a training burst, then back-to-back data
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, IDLE_W, 1'b0, 1'b0);
    train_burst(1'b0, 64'h0);
    data(P1, D1); data(P1, D1); data(P1, D1);
    data(P2, D2); data(P3, D3); data(P4, A5_W);

    // underflow counting
    for (int i = 0; i < 5; i++) under();
    check("uf_after_5", 64'(bus.o_underflow_count), 64'd5);

    // training request during an offered word: not consumed, re-offered after retrain
    step(1'b1, 1'b1, 1'b1, P2, 1'b0, IDLE_W, 1'b0, 1'b0);
    train_burst(1'b1, P2);
    data(P2, D2);
    under();

    // enable dropped mid-TRAIN, then a full burst on re-enable
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, IDLE_W, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, tw(0), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, IDLE_W, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, IDLE_W, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, IDLE_W, 1'b0, 1'b0);
    train_burst(1'b0, 64'h0);
    data(P3, D3);

    // enable low in RUN with valid data: nothing accepted
    step(1'b0, 1'b0, 1'b1, P1, 1'b0, IDLE_W, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, IDLE_W, 1'b0, 1'b0);
    train_burst(1'b0, 64'h0);
    data(P1, D1);

    // asynchronous reset mid-RUN
    bus.i_enable = 1'b1; bus.i_valid = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    bus.i_enable = 1'b0; bus.i_valid = 1'b0;
    @(posedge clk); #1;
    check_reset("held_rst");
    @(negedge clk) rst = 1'b0;
    uf_exp = '0;
    @(posedge clk) #1;

    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, IDLE_W, 1'b0, 1'b0);
    train_burst(1'b0, 64'h0);
    data(P2, D2);

    // saturation of the underflow counter
    while (uf_exp != 16'hFFFE) under();
    check("uf_fffe", 64'(bus.o_underflow_count), 64'hFFFE);
    under(); under(); under();
    check("uf_saturated", 64'(bus.o_underflow_count), 64'hFFFF);

    @(negedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serdes_scramble.md
# serdes_scramble

Transmit-side lane interleaver for the LVDS link. Accepts one byte per lane for eight lanes under a valid/ready handshake and packs them into the 64-bit bit-interleaved word consumed by the OSERDES bank. This is the exact inverse of the receive-side descramble mapping, so a loopback through both returns the original lane bytes. A small state machine inserts idle and training words so the serializer always sees a defined word every clock.

## Interface
- TRAIN_WORDS, 64: number of training words emitted per training burst (1..65535).
- TRAIN_BYTE, 8'hA5: per-lane training byte (fixed-pattern mode).
- IDLE_BYTE, 8'h00: per-lane byte emitted when no data is available.
- clk  in  1  serializer word clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  link enable; low forces IDLE.
- i_train_req  in  1  single-cycle request to start a training burst.
- i_lvds0..i_lvds7  in  8 each  lane bytes; bit 7 is the first bit serialized.
- i_valid  in  1  lane bytes valid.
- o_ready  out  1  word accepted this cycle when i_valid && o_ready.
- o_lvds  out  64  interleaved word to the OSERDES.
- o_train_active  out  1  current o_lvds word is a training word.
- o_underflow_count  out  16  saturating count of RUN cycles without i_valid.

## Operation
- Mapping: o_lvds[(7-b)*8 + (7-L)] = lane L bit b. Examples: lane0 bit7 -> o_lvds[7]; lane0 bit0 -> o_lvds[63]; lane7 bit0 -> o_lvds[56].
- States:
  - IDLE: emit IDLE_BYTE on all lanes.
    - i_enable=1 -> TRAIN.
  - TRAIN: emit a training word every cycle while a word counter counts 0..TRAIN_WORDS-1.
    - After word TRAIN_WORDS-1 -> RUN.
  - RUN: o_ready=1.
    - i_valid=1: the lane bytes are registered to o_lvds.
    - i_valid=0: emit the idle word and increment o_underflow_count, saturating at 16'hFFFF.
- i_train_req in RUN or TRAIN -> TRAIN with the counter cleared. Training restarts; the underflow counter is not cleared.
- i_train_req in IDLE is ignored.
- i_enable=0 in any state -> IDLE next cycle.
  - i_enable=0 has priority over i_train_req.
- o_ready = (state==RUN) && i_enable && !i_train_req. It is combinational from registered state and inputs. Data is never dropped on a state change.
- o_underflow_count is cleared only by rst.

## Timing
- Latency: a word accepted on cycle N appears on o_lvds during cycle N+1. o_train_active is aligned with o_lvds.
- Back-to-back accepts give one output word per clock, with no bubbles.
- TRAIN lasts exactly TRAIN_WORDS cycles of o_train_active=1.
  - The first RUN word is visible the cycle after the last training word.
- Reset values:
  - state IDLE.
  - o_lvds = idle word (IDLE_BYTE on all lanes, interleaved).
  - o_ready=0, o_train_active=0, o_underflow_count=0.
  - PRBS state 7'h7F.
- Reset asserted mid-burst or mid-RUN returns all of the above immediately. Output resumes through IDLE -> TRAIN after release.

## Configuration
- SERDES_SCRAMBLE_PRBS_EN defined:
  - Training bytes come from a PRBS-7 generator (x^7+x^6+1, seed 7'h7F). It advances 8 bits per training word, and the same byte goes on all lanes.
  - The MSB is the first LFSR output bit.
  - The LFSR is reseeded at each TRAIN entry.
- Not defined: every training word is TRAIN_BYTE on all lanes, and no LFSR is instantiated.

## Structure
- The shared package holds:
  - the state enum (IDLE, TRAIN, RUN);
  - LANES=8 and LANE_BITS=8;
  - the PRBS-7 seed and taps;
  - the interleave index function, which the receive-side descramble also uses.
- One sub-module, serdes_prbs7_byte, with clk, rst, i_load, i_advance and o_byte. It is instantiated only under SERDES_SCRAMBLE_PRBS_EN.

## Test plan
- Reset, then i_enable=1 with TRAIN_WORDS=4 and fixed mode:
  - o_lvds is the idle word;
  - 4 cycles of o_train_active=1 with the interleaved 8'hA5;
  - then o_ready=1.
- In RUN, lane L = 8'h01<<L with i_valid held for 3 cycles:
  - o_lvds = 64'h8040201008040201 one cycle later, for 3 cycles;
  - a loopback through the descramble returns the same lanes.
- i_valid low for 5 RUN cycles: 5 idle words and o_underflow_count=5. After preloading the counter to 16'hFFFE and running 3 more cycles, it sticks at 16'hFFFF.
- i_train_req pulse during a RUN accept:
  - o_ready=0 that cycle and the word is not consumed;
  - TRAIN restarts for TRAIN_WORDS cycles;
  - the held word is then emitted first in RUN.
- i_enable dropped mid-TRAIN: IDLE next cycle, then a full TRAIN_WORDS burst on re-enable. rst pulsed mid-RUN: all outputs at their reset values asynchronously.
- With SERDES_SCRAMBLE_PRBS_EN: the training bytes match the PRBS-7 reference sequence from seed 7'h7F, and the sequence restarts identically on a second training burst.
